instruction_decode: RTL and testbench

//   RV32I decode stage; sits directly downstream of instruction fetch.

---
 rtl/cpu_defs_pkg.sv | 52 +++++
 rtl/register_file.sv | 47 ++++
 rtl/instruction_decode.sv | 147 ++++++++++++++
 tb/tb_instruction_decode.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, fetch-select and writeback-select codes.
package cpu_defs_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] BR_PC4    = 2'b00;
  localparam logic [1:0] BR_TARGET = 2'b01;
  localparam logic [1:0] BR_ALU    = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // alt selects SUB/SRA over ADD/SRL (instruction bit 30)
  function automatic logic [3:0] alu_from_funct3(logic [2:0] funct3, logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: synchronous write, asynchronous read, x0 hardwired to zero,
// optional same-cycle write-to-read forwarding.
module register_file #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter bit          BYPASS  = 1'b1,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regs [REG_NUM];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    if (!rst_n || addr == '0) begin
      val = '0;
    end else if (BYPASS && wb_en && wb_addr == addr) begin
      val = wb_data;
    end else begin
      val = regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: register operands, immediate, control signals and the branch
// decision returned to fetch.
module instruction_decode
  import cpu_defs_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd_addr,
  output logic [3:0]      alu_ctrl,
  output logic            alu_src_a,
  output logic            alu_src_b,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_funct3,
  output logic [1:0]      wb_sel,
  output logic            reg_write,
  output logic [1:0]      branch,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        taken;

  // pc feeds the ALU downstream via alu_src_a; decode itself never looks at it
  logic unused_pc;
  assign unused_pc = ^pc;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign funct7     = instruction[31:25];
  assign rd_addr    = instruction[11:7];
  assign mem_funct3 = funct3;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  register_file #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM),
    .BYPASS  (BYPASS)
  ) u_register_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rs1_addr (instruction[19:15]),
    .rs2_addr (instruction[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always_comb begin
    unique case (funct3)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data < rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imm       = '0;
    alu_ctrl  = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = WB_ALU;
    reg_write = 1'b0;
    branch    = BR_PC4;
    illegal   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm = imm_u; alu_ctrl = ALU_PASS_B; alu_src_b = 1'b1; reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm = imm_u; alu_src_a = 1'b1; alu_src_b = 1'b1; reg_write = 1'b1;
      end
      OP_JAL: begin
        imm = imm_j; wb_sel = WB_PC4; reg_write = 1'b1; branch = BR_TARGET;
      end
      OP_JALR: begin
        imm = imm_i; alu_src_b = 1'b1; wb_sel = WB_PC4; reg_write = 1'b1; branch = BR_ALU;
        illegal = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        imm = imm_b; alu_ctrl = ALU_SUB; branch = taken ? BR_TARGET : BR_PC4;
        illegal = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        imm = imm_i; alu_src_b = 1'b1; mem_read = 1'b1; reg_write = 1'b1; wb_sel = WB_MEM;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        imm = imm_s; alu_src_b = 1'b1; mem_write = 1'b1;
        illegal = funct3[2] || (funct3 == 3'b011);
      end
      OP_IMM: begin
        imm = imm_i; alu_src_b = 1'b1; reg_write = 1'b1;
        alu_ctrl = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OP_REG: begin
        reg_write = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
        illegal   = !((funct7 == 7'h00) ||
                      ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_FENCE:  illegal = (funct3 != 3'b000);
      // only ECALL and EBREAK; CSR instructions are outside RV32I
      OP_SYSTEM: illegal = (instruction != 32'h0000_0073) && (instruction != 32'h0010_0073);
      default:   illegal = 1'b1;
    endcase
    if (illegal) begin
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = BR_PC4;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed scenarios then randomized instructions,
// checked against a mnemonic-level reference model with its own register array.
module tb_instruction_decode;
  import cpu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'h13, pc = '0, wb_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd_addr;
  logic [3:0]  alu_ctrl;
  logic        alu_src_a, alu_src_b, mem_read, mem_write, reg_write, illegal;
  logic [2:0]  mem_funct3;
  logic [1:0]  wb_sel, branch;

  instruction_decode #(.XLEN(32), .REG_NUM(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc(pc), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .rd_addr(rd_addr), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .wb_sel(wb_sel), .reg_write(reg_write), .branch(branch),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src_a, src_b, mrd, mwr;
    logic [2:0]  f3;
    logic [1:0]  wbs;
    logic        rw;
    logic [1:0]  br;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [31:0] mregs [32];
  int          checks = 0;
  int          errors = 0;

  // ---------------- reference model ----------------
  function automatic string mnem(logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    string      m  = "";
    case (i[6:0])
      7'h37: m = "lui";
      7'h17: m = "auipc";
      7'h6F: m = "jal";
      7'h67: if (f3 == 0) m = "jalr";
      7'h63: case (f3) 0: m = "beq"; 1: m = "bne"; 4: m = "blt"; 5: m = "bge";
                       6: m = "bltu"; 7: m = "bgeu"; default: m = ""; endcase
      7'h03: case (f3) 0: m = "lb"; 1: m = "lh"; 2: m = "lw"; 4: m = "lbu"; 5: m = "lhu";
                       default: m = ""; endcase
      7'h23: case (f3) 0: m = "sb"; 1: m = "sh"; 2: m = "sw"; default: m = ""; endcase
      7'h13: case (f3) 0: m = "addi"; 2: m = "slti"; 3: m = "sltiu"; 4: m = "xori";
                       6: m = "ori"; 7: m = "andi";
                       1: if (f7 == 0) m = "slli";
                       default: m = (f7 == 0) ? "srli" : (f7 == 7'h20) ? "srai" : "";
                     endcase
      7'h33: if (f7 == 0) begin
               case (f3) 0: m = "add"; 1: m = "sll"; 2: m = "slt"; 3: m = "sltu";
                         4: m = "xor"; 5: m = "srl"; 6: m = "or"; default: m = "and"; endcase
             end else if (f7 == 7'h20) begin
               if (f3 == 0) m = "sub"; else if (f3 == 5) m = "sra";
             end
      7'h0F: if (f3 == 0) m = "fence";
      7'h73: if (i == 32'h73) m = "ecall"; else if (i == 32'h0010_0073) m = "ebreak";
      default: m = "";
    endcase
    return m;
  endfunction

  function automatic logic [3:0] alu_of(string m);
    case (m)
      "lui": return ALU_PASS_B;
      "sub", "beq", "bne", "blt", "bge", "bltu", "bgeu": return ALU_SUB;
      "sll", "slli": return ALU_SLL;
      "slt", "slti": return ALU_SLT;
      "sltu", "sltiu": return ALU_SLTU;
      "xor", "xori": return ALU_XOR;
      "srl", "srli": return ALU_SRL;
      "sra", "srai": return ALU_SRA;
      "or", "ori": return ALU_OR;
      "and", "andi": return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic taken_of(string m, logic [31:0] a, logic [31:0] b);
    case (m)
      "beq":  return a == b;
      "bne":  return a != b;
      "blt":  return $signed(a) < $signed(b);
      "bge":  return $signed(a) >= $signed(b);
      "bltu": return a < b;
      default: return a >= b;
    endcase
  endfunction

  function automatic logic [31:0] read_reg(logic [4:0] a);
    if (!rst_n || a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic exp_t model(logic [31:0] i);
    exp_t  e = '0;
    string m = mnem(i);
    e.rs1 = read_reg(i[19:15]);
    e.rs2 = read_reg(i[24:20]);
    e.rd  = i[11:7];
    e.f3  = i[14:12];
    e.ill = (m == "");
    e.alu = alu_of(m);
    case (i[6:0])
      7'h37, 7'h17: e.imm = {i[31:12], 12'h000};
      7'h6F: e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      7'h67, 7'h03, 7'h13: e.imm = {{20{i[31]}}, i[31:20]};
      7'h23: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63: e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: e.imm = 32'h0;
    endcase
    if (!e.ill) begin
      case (i[6:0])
        7'h37: begin e.src_b = 1; e.rw = 1; end
        7'h17: begin e.src_a = 1; e.src_b = 1; e.rw = 1; end
        7'h6F: begin e.br = 2'b01; e.wbs = 2'b10; e.rw = 1; end
        7'h67: begin e.br = 2'b10; e.wbs = 2'b10; e.rw = 1; e.src_b = 1; end
        7'h63: e.br = taken_of(m, e.rs1, e.rs2) ? 2'b01 : 2'b00;
        7'h03: begin e.mrd = 1; e.rw = 1; e.wbs = 2'b01; e.src_b = 1; end
        7'h23: begin e.mwr = 1; e.src_b = 1; end
        7'h13: begin e.rw = 1; e.src_b = 1; end
        7'h33: e.rw = 1;
        default: ;
      endcase
    end
    return e;
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_type(logic [11:0] im, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_type(logic [11:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_type(logic [12:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rn, input string nm);
    instruction = ins; wb_en = we; wb_addr = wa; wb_data = wd; rst_n = rn; pc = $urandom;
    exp_q.push_back(model(ins));
    name_q.push_back(nm);
    @(posedge clk);
    if (!rn) mregs = '{default: 32'h0};
    else if (we && wa != 0) mregs[wa] = wd;
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got %08h expected %08h", nm, fld, act, want);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "rs1_data",  rs1_data,         e.rs1);
        chk(nm, "rs2_data",  rs2_data,         e.rs2);
        chk(nm, "illegal",   32'(illegal),     32'(e.ill));
        chk(nm, "reg_write", 32'(reg_write),   32'(e.rw));
        chk(nm, "mem_read",  32'(mem_read),    32'(e.mrd));
        chk(nm, "mem_write", 32'(mem_write),   32'(e.mwr));
        chk(nm, "branch",    32'(branch),      32'(e.br));
        chk(nm, "rd_addr",   32'(rd_addr),     32'(e.rd));
        chk(nm, "funct3",    32'(mem_funct3),  32'(e.f3));
        if (!e.ill) begin
          chk(nm, "imm",       imm,              e.imm);
          chk(nm, "alu_ctrl",  32'(alu_ctrl),    32'(e.alu));
          chk(nm, "alu_src_a", 32'(alu_src_a),   32'(e.src_a));
          chk(nm, "alu_src_b", 32'(alu_src_b),   32'(e.src_b));
          chk(nm, "wb_sel",    32'(wb_sel),      32'(e.wbs));
        end
      end
    end
  end

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                           7'h0F, 7'h73};

  initial begin : stim
    logic [31:0] ins;
    mregs = '{default: 32'h0};
    @(posedge clk); #1;
    step(32'h13, 1'b0, 5'd0, 32'h0, 1'b0, "reset0");
    step(32'h13, 1'b1, 5'd4, 32'h1111, 1'b0, "reset1");

    step(32'h13, 1'b1, 5'd5, 32'h0000_1234, 1'b1, "t1_wr");
    step(i_type(12'hFFF, 5'd5, 3'b000, 5'd6, 7'h13), 1'b0, 5'd0, 32'h0, 1'b1, "t1_addi");

    step(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, "t2_same");
    step(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 1'b0, 5'd0, 32'h0, 1'b1, "t2_next");

    step(r_type(7'h00, 5'd7, 5'd7, 3'b000, 5'd8), 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, "t3_bypass");

    step(32'h13, 1'b1, 5'd1, 32'h8000_0000, 1'b1, "t4_wr1");
    step(32'h13, 1'b1, 5'd2, 32'h0000_0001, 1'b1, "t4_wr2");
    step(b_type(13'h010, 5'd2, 5'd1, 3'b100), 1'b0, 5'd0, 32'h0, 1'b1, "t4_blt");
    step(b_type(13'h010, 5'd2, 5'd1, 3'b110), 1'b0, 5'd0, 32'h0, 1'b1, "t4_bltu");
    step(b_type(13'h1FF0, 5'd1, 5'd1, 3'b000), 1'b0, 5'd0, 32'h0, 1'b1, "t4_beq");
    step(i_type(12'h000, 5'd2, 3'b000, 5'd1, 7'h67), 1'b0, 5'd0, 32'h0, 1'b1, "t4_jalr");
    step(s_type(12'hFFC, 5'd2, 5'd1, 3'b010), 1'b0, 5'd0, 32'h0, 1'b1, "t7_sw");
    step(32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, "t6_illegal");

    for (int r = 1; r < 32; r++) step(32'h13, 1'b1, 5'(r), $urandom, 1'b1, "t5_fill");
    step(32'h13, 1'b1, 5'd3, 32'h3333_3333, 1'b0, "t5_reset");
    for (int r = 1; r < 32; r++)
      step(r_type(7'h00, 5'(r), 5'(r), 3'b000, 5'(r)), 1'b0, 5'd0, 32'h0, 1'b1, "t5_read");

    for (int r = 1; r < 32; r++) step(32'h13, 1'b1, 5'(r), $urandom, 1'b1, "rand_fill");
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        ins[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 3) == 0) ins[24:20] = ins[19:15];
      end else if ($urandom_range(0, 1) == 1) begin
        ins = ($urandom_range(0, 1) == 1) ? 32'h0000_0073 : 32'h0010_0073;
      end
      step(ins, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           ($urandom_range(0, 49) != 0), "rand");
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
